// File: rtl/aria_round_key_gen.sv
// aria_round_key_gen: sequential ARIA round-key issuer driven from W0..W3.
// Define ARIA_DEC_KEY_EN to compile in decryption order and layer A.
module aria_round_key_gen (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] w0,
  input  logic [127:0] w1,
  input  logic [127:0] w2,
  input  logic [127:0] w3,
  input  logic [1:0]   key_len,
  input  logic         dec,
  input  logic         start,
  output logic [127:0] rk,
  output logic [4:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t       state;
  logic [127:0] w_q [4];
  logic [4:0]   nr_q;
  logic [127:0] sw [4];
  logic [4:0]   snr;
  logic [4:0]   nk;
  logic [4:0]   e;
  logic [4:0]   e1;
  logic [127:0] ek;
  logic [127:0] nxt;
  logic         hs;

`ifdef ARIA_DEC_KEY_EN
  logic dec_q;
  logic sdec;
  logic use_a;
`else
  logic unused_dec;
  assign unused_dec = dec;
`endif

  assign hs = rk_valid & rk_ready;

  function automatic logic [4:0] nr_of(input logic [1:0] kl);
    unique case (kl)
      2'd0:    return 5'd12;
      2'd1:    return 5'd14;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [127:0] rot(
    input logic [127:0] x,
    input logic [2:0]   g
  );
    unique case (g)
      3'd0:    return {x[18:0], x[127:19]};
      3'd1:    return {x[30:0], x[127:31]};
      3'd2:    return {x[66:0], x[127:67]};
      3'd3:    return {x[96:0], x[127:97]};
      default: return {x[108:0], x[127:109]};
    endcase
  endfunction

`ifdef ARIA_DEC_KEY_EN
  function automatic logic [127:0] diff_a(input logic [127:0] x);
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++)
      b[i] = x[127-8*i -: 8];
    return {
      b[3]^b[4]^b[6]^b[8]^b[9]^b[13]^b[14],
      b[2]^b[5]^b[7]^b[8]^b[9]^b[12]^b[15],
      b[1]^b[4]^b[6]^b[10]^b[11]^b[12]^b[15],
      b[0]^b[5]^b[7]^b[10]^b[11]^b[13]^b[14],
      b[0]^b[2]^b[5]^b[8]^b[11]^b[14]^b[15],
      b[1]^b[3]^b[4]^b[9]^b[10]^b[14]^b[15],
      b[0]^b[2]^b[7]^b[9]^b[10]^b[12]^b[13],
      b[1]^b[3]^b[6]^b[8]^b[11]^b[12]^b[13],
      b[0]^b[1]^b[4]^b[7]^b[10]^b[13]^b[15],
      b[0]^b[1]^b[5]^b[6]^b[11]^b[12]^b[14],
      b[2]^b[3]^b[5]^b[6]^b[8]^b[13]^b[15],
      b[2]^b[3]^b[4]^b[7]^b[9]^b[12]^b[14],
      b[1]^b[2]^b[6]^b[7]^b[9]^b[11]^b[12],
      b[0]^b[3]^b[6]^b[7]^b[8]^b[10]^b[13],
      b[0]^b[3]^b[4]^b[5]^b[9]^b[11]^b[14],
      b[1]^b[2]^b[4]^b[5]^b[8]^b[10]^b[15]
    };
  endfunction
`endif

  // next key: source words, output slot, ek index, optional layer A
  always_comb begin
    if (state == IDLE) begin
      sw[0] = w0;
      sw[1] = w1;
      sw[2] = w2;
      sw[3] = w3;
      snr   = nr_of(key_len);
      nk    = 5'd1;
    end else begin
      sw  = w_q;
      snr = nr_q;
      nk  = rk_idx + 5'd1;
    end
    e = nk;
`ifdef ARIA_DEC_KEY_EN
    sdec  = (state == IDLE) ? dec : dec_q;
    use_a = 1'b0;
    if (sdec) begin
      if (nk == 5'd1) begin
        e = snr + 5'd1;
      end else if (nk == snr + 5'd1) begin
        e = 5'd1;
      end else begin
        e     = snr + 5'd2 - nk;
        use_a = 1'b1;
      end
    end
`endif
    e1  = e - 5'd1;
    ek  = sw[e1[1:0]] ^ rot(sw[e1[1:0] + 2'd1], e1[4:2]);
    nxt = ek;
`ifdef ARIA_DEC_KEY_EN
    if (use_a) nxt = diff_a(ek);
`endif
  end

  // sequence FSM with registered key outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      w_q      <= '{default: '0};
      nr_q     <= '0;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ARIA_DEC_KEY_EN
      dec_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= GEN;
            w_q[0]   <= w0;
            w_q[1]   <= w1;
            w_q[2]   <= w2;
            w_q[3]   <= w3;
            nr_q     <= snr;
`ifdef ARIA_DEC_KEY_EN
            dec_q    <= dec;
`endif
            rk       <= nxt;
            rk_idx   <= nk;
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        GEN: begin
          if (hs) begin
            if (rk_last) begin
              state    <= DONE;
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk      <= nxt;
              rk_idx  <= nk;
              rk_last <= (nk == nr_q + 5'd1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
